// File: rtl/alu16bit_scheduler.sv
// Round-robin front end sharing one alu16bit between two requesters.
// One operation in flight; the response is held until its owner takes it.
module alu16bit_scheduler #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [2:0]  req_op_0,
  input  logic [2:0]  req_op_1,
  input  logic [15:0] req_a_0,
  input  logic [15:0] req_a_1,
  input  logic [15:0] req_b_0,
  input  logic [15:0] req_b_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic [2:0]  alu_operation,
  output logic [15:0] alu_operand_A,
  output logic [15:0] alu_operand_B,
  input  logic [31:0] alu_result,
  input  logic        alu_carry_flag,
  input  logic        alu_zero_flag,
  output logic        busy,
  output logic        owner,
  output logic [1:0]  fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a requester keeps valid and its payload stable until ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic       prio;
  logic [2:0] cnt;
  logic       grant_0;
  logic       grant_1;
  logic       owner_ready;

  always_comb begin
    grant_0     = req_valid_0 && (!prio || !req_valid_1);
    grant_1     = req_valid_1 && (prio || !req_valid_0);
    owner_ready = owner ? rsp_ready_1 : rsp_ready_0;
  end

  // Gated by reset so the ready outputs read 0 while reset is asserted.
  assign req_ready_0 = reset && (state == IDLE) && grant_0;
  assign req_ready_1 = reset && (state == IDLE) && grant_1;
  assign rsp_valid_0 = (state == RESP) && !owner;
  assign rsp_valid_1 = (state == RESP) && owner;
  assign busy        = (state != IDLE);
  assign fsm_state   = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      prio          <= 1'b0;
      cnt           <= 3'd0;
      owner         <= 1'b0;
      alu_operation <= 3'd0;
      alu_operand_A <= 16'd0;
      alu_operand_B <= 16'd0;
      rsp_result    <= 32'd0;
      rsp_carry     <= 1'b0;
      rsp_zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_0 || grant_1) begin
            alu_operation <= grant_1 ? req_op_1 : req_op_0;
            alu_operand_A <= grant_1 ? req_a_1 : req_a_0;
            alu_operand_B <= grant_1 ? req_b_1 : req_b_0;
            owner         <= grant_1;
            cnt           <= 3'(ALU_LATENCY);
            state         <= WAIT;
          end
        end
        WAIT: begin
          // cnt hits zero on the edge after the ALU pipeline has drained.
          if (cnt == 3'd0) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry_flag;
            rsp_zero   <= alu_zero_flag;
            state      <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (owner_ready) begin
            prio  <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16bit_scheduler.sv
// Scoreboarded bench for alu16bit_scheduler with behavioural ALU stand-ins
// at latencies 1 (main), 0 and 3 (latency sweep).
module tb_alu16bit_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // ---------------- main DUT (ALU_LATENCY = 1) ----------------
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic        req_ready_0, req_ready_1;
  logic [2:0]  req_op_0 = '0, req_op_1 = '0;
  logic [15:0] req_a_0 = '0, req_a_1 = '0, req_b_0 = '0, req_b_1 = '0;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0 = 1'b1, rsp_ready_1 = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_zero;
  logic [2:0]  alu_operation;
  logic [15:0] alu_operand_A, alu_operand_B;
  logic [31:0] alu_result;
  logic        alu_carry_flag, alu_zero_flag;
  logic        busy, owner;
  logic [1:0]  fsm_state;

  // Behavioural ALU: {carry, zero, result}.
  function automatic logic [33:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    case (op)
      3'd0: {c, r[15:0]} = {1'b0, a} + {1'b0, b};
      3'd1: {c, r[15:0]} = {1'b0, a} - {1'b0, b};
      3'd2: r = 32'(a) * 32'(b);
      3'd3: r[15:0] = a & b;
      3'd4: r[15:0] = a | b;
      3'd5: r[15:0] = ~(a & b);
      3'd6: r[15:0] = ~(a | b);
      default: r[15:0] = a ^ b;
    endcase
    return {c, (r == 32'd0), r};
  endfunction

  always @(posedge clk)
    {alu_carry_flag, alu_zero_flag, alu_result} <= alu_f(alu_operation, alu_operand_A, alu_operand_B);

  alu16bit_scheduler #(.ALU_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .alu_operation(alu_operation), .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B),
    .alu_result(alu_result), .alu_carry_flag(alu_carry_flag), .alu_zero_flag(alu_zero_flag),
    .busy(busy), .owner(owner), .fsm_state(fsm_state)
  );

  // ---------------- latency sweep DUTs (0 and 3) ----------------
  logic        sw_valid = 1'b0;
  logic [2:0]  sw_op = '0;
  logic [15:0] sw_a = '0, sw_b = '0;

  logic        l0_req_ready_0, l0_req_ready_1, l0_rsp_valid_0, l0_rsp_valid_1;
  logic [31:0] l0_rsp_result, l0_alu_result;
  logic        l0_rsp_carry, l0_rsp_zero, l0_alu_carry_flag, l0_alu_zero_flag, l0_busy, l0_owner;
  logic [2:0]  l0_alu_operation;
  logic [15:0] l0_alu_operand_A, l0_alu_operand_B;
  logic [1:0]  l0_fsm_state;

  assign {l0_alu_carry_flag, l0_alu_zero_flag, l0_alu_result} =
    alu_f(l0_alu_operation, l0_alu_operand_A, l0_alu_operand_B);

  alu16bit_scheduler #(.ALU_LATENCY(0)) dut_l0 (
    .clk(clk), .reset(reset),
    .req_valid_0(sw_valid), .req_valid_1(1'b0),
    .req_ready_0(l0_req_ready_0), .req_ready_1(l0_req_ready_1),
    .req_op_0(sw_op), .req_op_1(3'd0),
    .req_a_0(sw_a), .req_a_1(16'd0),
    .req_b_0(sw_b), .req_b_1(16'd0),
    .rsp_valid_0(l0_rsp_valid_0), .rsp_valid_1(l0_rsp_valid_1),
    .rsp_ready_0(1'b1), .rsp_ready_1(1'b1),
    .rsp_result(l0_rsp_result), .rsp_carry(l0_rsp_carry), .rsp_zero(l0_rsp_zero),
    .alu_operation(l0_alu_operation), .alu_operand_A(l0_alu_operand_A),
    .alu_operand_B(l0_alu_operand_B),
    .alu_result(l0_alu_result), .alu_carry_flag(l0_alu_carry_flag),
    .alu_zero_flag(l0_alu_zero_flag),
    .busy(l0_busy), .owner(l0_owner), .fsm_state(l0_fsm_state)
  );

  logic        l3_req_ready_0, l3_req_ready_1, l3_rsp_valid_0, l3_rsp_valid_1;
  logic [31:0] l3_rsp_result, l3_alu_result;
  logic        l3_rsp_carry, l3_rsp_zero, l3_alu_carry_flag, l3_alu_zero_flag, l3_busy, l3_owner;
  logic [2:0]  l3_alu_operation;
  logic [15:0] l3_alu_operand_A, l3_alu_operand_B;
  logic [1:0]  l3_fsm_state;
  logic [33:0] l3_pipe [3];

  always @(posedge clk) begin
    l3_pipe[0] <= alu_f(l3_alu_operation, l3_alu_operand_A, l3_alu_operand_B);
    l3_pipe[1] <= l3_pipe[0];
    l3_pipe[2] <= l3_pipe[1];
  end
  assign {l3_alu_carry_flag, l3_alu_zero_flag, l3_alu_result} = l3_pipe[2];

  alu16bit_scheduler #(.ALU_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .req_valid_0(sw_valid), .req_valid_1(1'b0),
    .req_ready_0(l3_req_ready_0), .req_ready_1(l3_req_ready_1),
    .req_op_0(sw_op), .req_op_1(3'd0),
    .req_a_0(sw_a), .req_a_1(16'd0),
    .req_b_0(sw_b), .req_b_1(16'd0),
    .rsp_valid_0(l3_rsp_valid_0), .rsp_valid_1(l3_rsp_valid_1),
    .rsp_ready_0(1'b1), .rsp_ready_1(1'b1),
    .rsp_result(l3_rsp_result), .rsp_carry(l3_rsp_carry), .rsp_zero(l3_rsp_zero),
    .alu_operation(l3_alu_operation), .alu_operand_A(l3_alu_operand_A),
    .alu_operand_B(l3_alu_operand_B),
    .alu_result(l3_alu_result), .alu_carry_flag(l3_alu_carry_flag),
    .alu_zero_flag(l3_alu_zero_flag),
    .busy(l3_busy), .owner(l3_owner), .fsm_state(l3_fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  bit          grant_log[$];
  int          acc_edge[2];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (req_ready_0) grant_log.push_back(1'b0);
      if (req_ready_1) grant_log.push_back(1'b1);
      if (rsp_valid_0 || rsp_valid_1)
        check("single_rsp_valid", 80'(rsp_valid_0 && rsp_valid_1), 80'(0));
      if (rsp_valid_0 && rsp_ready_0) begin
        if (exp_q0.size() == 0) check("rsp0_unexpected", 80'(1), 80'(0));
        else check("rsp0_data", 80'({rsp_carry, rsp_zero, rsp_result}), 80'(exp_q0.pop_front()));
      end
      if (rsp_valid_1 && rsp_ready_1) begin
        if (exp_q1.size() == 0) check("rsp1_unexpected", 80'(1), 80'(0));
        else check("rsp1_data", 80'({rsp_carry, rsp_zero, rsp_result}), 80'(exp_q1.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit p, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [33:0] exp);
    int n;
    n = 0;
    if (!p) begin
      exp_q0.push_back(exp);
      req_op_0 = op; req_a_0 = a; req_b_0 = b; req_valid_0 = 1'b1;
    end else begin
      exp_q1.push_back(exp);
      req_op_1 = op; req_a_1 = a; req_b_1 = b; req_valid_1 = 1'b1;
    end
    @(negedge clk);
    while (!(p ? req_ready_1 : req_ready_0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(p ? req_ready_1 : req_ready_0)) check("accept_timeout", 80'(p), 80'(2));
    else acc_edge[p] = cyc + 1;
    tick();
    if (!p) req_valid_0 = 1'b0;
    else req_valid_1 = 1'b0;
  endtask

  task automatic wait_rsp(input bit p, output int edge_n);
    int n;
    n = 0;
    edge_n = -1;
    @(negedge clk);
    while (!(p ? rsp_valid_1 : rsp_valid_0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(p ? rsp_valid_1 : rsp_valid_0)) check("rsp_timeout", 80'(p), 80'(2));
    else edge_n = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check("drain", 80'({exp_q0.size() != 0, exp_q1.size() != 0, busy}), 80'(0));
    tick();
  endtask

  int  e, h, lat0, lat3, v0n, v3n, busy_bad, n;
  logic [31:0] res0, res3;
  bit  p0_done;

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          80'({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_result, rsp_carry, rsp_zero,
               alu_operation, alu_operand_A, alu_operand_B, busy, owner}), 80'(0));
    reset = 1'b1;
    tick();

    // Single ADD on port 0
    grant_log.delete();
    issue(1'b0, 3'd0, 16'h0005, 16'h0003, {2'b00, 32'h0000_0008});
    wait_rsp(1'b0, e);
    check("add_latency", 80'(e - acc_edge[0]), 80'(2));
    drain();
    check("add_grant_count", 80'(grant_log.size()), 80'(1));

    // Single SUB on port 1 hands priority back to port 0
    issue(1'b1, 3'd1, 16'h0009, 16'h0004, {2'b00, 32'h0000_0005});
    drain();

    // Contention: both valid continuously
    grant_log.delete();
    fork
      begin
        issue(1'b0, 3'd2, 16'h000A, 16'h0002, {2'b00, 32'h0000_0014});
        issue(1'b0, 3'd2, 16'h000A, 16'h0002, {2'b00, 32'h0000_0014});
      end
      begin
        issue(1'b1, 3'd1, 16'h0009, 16'h0004, {2'b00, 32'h0000_0005});
        issue(1'b1, 3'd1, 16'h0009, 16'h0004, {2'b00, 32'h0000_0005});
      end
    join
    drain();
    if (grant_log.size() != 4) check("grant_count", 80'(grant_log.size()), 80'(4));
    else check("grant_order", 80'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}),
               80'(4'b0101));

    // Backpressure on port 1 while port 0 waits
    rsp_ready_1 = 1'b0;
    issue(1'b1, 3'd7, 16'h00F0, 16'h0F0F, {2'b00, 32'h0000_0FFF});
    p0_done = 1'b0;
    fork
      begin
        issue(1'b0, 3'd0, 16'h0001, 16'h0001, {2'b00, 32'h0000_0002});
        p0_done = 1'b1;
      end
    join_none
    wait_rsp(1'b1, e);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 80'({rsp_valid_1, req_ready_0, rsp_result}), 80'({1'b1, 1'b0, 32'h0000_0FFF}));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready_1 = 1'b1;
    h = cyc + 1;
    n = 0;
    while (!p0_done && n < 100) begin
      tick();
      n++;
    end
    check("bp_p0_accepted", 80'(p0_done), 80'(1));
    check("bp_accept_gap", 80'(acc_edge[0] - h), 80'(1));
    drain();

    // Zero flag
    issue(1'b0, 3'd3, 16'h00F0, 16'h0F0F, {2'b01, 32'h0000_0000});
    drain();
    issue(1'b0, 3'd4, 16'h00F0, 16'h0F0F, {2'b00, 32'h0000_0FFF});
    drain();

    // Latency sweep on the ALU_LATENCY=0 and =3 instances
    sw_op = 3'd0; sw_a = 16'h0005; sw_b = 16'h0003; sw_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!l0_req_ready_0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sweep_accept", 80'({l0_req_ready_0, l3_req_ready_0}), 80'(2'b11));
    e = cyc + 1;
    tick();
    sw_valid = 1'b0;
    lat0 = -1; lat3 = -1; v0n = 0; v3n = 0; busy_bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (lat0 < 0 && !l0_busy) busy_bad++;
      if (lat3 < 0 && !l3_busy) busy_bad++;
      if (l0_rsp_valid_0) begin
        v0n++;
        if (!l0_busy) busy_bad++;
        if (lat0 < 0) begin lat0 = cyc - e; res0 = l0_rsp_result; end
      end
      if (l3_rsp_valid_0) begin
        v3n++;
        if (!l3_busy) busy_bad++;
        if (lat3 < 0) begin lat3 = cyc - e; res3 = l3_rsp_result; end
      end
    end
    check("lat0_latency", 80'(lat0), 80'(1));
    check("lat3_latency", 80'(lat3), 80'(4));
    check("lat0_result", 80'(res0), 80'(32'h8));
    check("lat3_result", 80'(res3), 80'(32'h8));
    check("resp_one_cycle", 80'({v0n[7:0], v3n[7:0]}), 80'({8'd1, 8'd1}));
    check("sweep_busy", 80'(busy_bad), 80'(0));
    tick();

    // Reset in the middle of WAIT on a port 1 request (no response expected)
    req_op_1 = 3'd0; req_a_1 = 16'h0002; req_b_1 = 16'h0002; req_valid_1 = 1'b1;
    @(negedge clk);
    n = 0;
    while (!req_ready_1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tick();
    req_valid_1 = 1'b0;
    check("pre_reset_wait", 80'({busy, alu_operand_A}), 80'({1'b1, 16'h0002}));
    reset = 1'b0;
    #1;
    check("midwait_reset_outputs",
          80'({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_result, rsp_carry, rsp_zero,
               alu_operation, alu_operand_A, alu_operand_B, busy, owner}), 80'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    v0n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid_0 || rsp_valid_1 || busy) v0n++;
    end
    check("no_rsp_after_reset", 80'(v0n), 80'(0));
    tick();
    grant_log.delete();
    fork
      issue(1'b0, 3'd4, 16'h1200, 16'h0034, {2'b00, 32'h0000_1234});
      issue(1'b1, 3'd3, 16'h1234, 16'h1200, {2'b00, 32'h0000_1200});
    join
    drain();
    if (grant_log.size() == 0) check("post_reset_grant_count", 80'(0), 80'(2));
    else check("post_reset_first_grant", 80'(grant_log[0]), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
